control_unit: RTL and testbench

Multi-cycle sequencer for the K&S processor. It drives every control input of `data_path`, using the decoded instruction and registered ALU flags returned by the datapath. It steps each instruction through fetch, decode and execute, and stretches RAM accesses by a parameterised read latency. It sits beside `data_path` inside the processor top level and is the only source of PC, IR, register-file, flag and RAM write enables.

---
 rtl/k_and_s_pkg.sv | 89 ++++++++
 rtl/control_unit_if.sv | 36 +++
 rtl/control_unit.sv | 115 +++++++++++
 tb/tb_control_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and constants for the K&S processor.
//   decoded_instruction_type : instruction classes decoded from IR by data_path
//   ctrl_state_type          : control_unit sequencer states
//   ctrl_out_t               : bundle of every control strobe driven into data_path
//   ALU_*                    : ALU operation encodings (both units use these)
//   dispatch / alu_op / branch_taken : decode helpers used by control_unit
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP    = 4'h0,
      I_LOAD   = 4'h1,
      I_STORE  = 4'h2,
      I_MOVE   = 4'h3,
      I_ADD    = 4'h4,
      I_SUB    = 4'h5,
      I_AND    = 4'h6,
      I_OR     = 4'h7,
      I_BRANCH = 4'h8,
      I_BZERO  = 4'h9,
      I_BNZERO = 4'hA,
      I_BNEG   = 4'hB,
      I_BNNEG  = 4'hC,
      I_HALT   = 4'hF
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      FETCH,
      LOAD_IR,
      DECODE,
      EXEC_ALU,
      LOAD_WAIT,
      LOAD_WB,
      STORE,
      EXEC_BRANCH,
      HALT
   } ctrl_state_type;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       pc_enable;
      logic       ir_enable;
      logic       addr_sel;
      logic       c_sel;
      logic [1:0] operation;
      logic       write_reg_enable;
      logic       flags_reg_enable;
      logic       ram_write_enable;
      logic       halt;
   } ctrl_out_t;

   // Unlisted encodings fall back to FETCH, i.e. behave as NOP.
   function automatic ctrl_state_type dispatch(decoded_instruction_type di);
      case (di)
         I_ADD, I_SUB, I_AND, I_OR, I_MOVE:              return EXEC_ALU;
         I_LOAD:                                         return LOAD_WAIT;
         I_STORE:                                        return STORE;
         I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:   return EXEC_BRANCH;
         I_HALT:                                         return HALT;
         default:                                        return FETCH;
      endcase
   endfunction

   // MOVE shares the OR encoding so the ALU computes A|A.
   function automatic logic [1:0] alu_op(decoded_instruction_type di);
      case (di)
         I_SUB:        return ALU_SUB;
         I_AND:        return ALU_AND;
         I_OR, I_MOVE: return ALU_OR;
         default:      return ALU_ADD;
      endcase
   endfunction

   function automatic logic branch_taken(decoded_instruction_type di, logic zero, logic neg);
      case (di)
         I_BRANCH: return 1'b1;
         I_BZERO:  return zero;
         I_BNZERO: return !zero;
         I_BNEG:   return neg;
         I_BNNEG:  return !neg;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: control/status bundle between control_unit and data_path.
//   master : control_unit side (reads decode and flags, drives strobes)
//   slave  : data_path side (drives decode and flags, reads strobes)
interface control_unit_if;
   import k_and_s_pkg::*;

   decoded_instruction_type decoded_instruction;
   logic                    zero_op;
   logic                    neg_op;
   logic                    unsigned_overflow;
   logic                    signed_overflow;

   logic                    branch;
   logic                    pc_enable;
   logic                    ir_enable;
   logic                    addr_sel;
   logic                    c_sel;
   logic [1:0]              operation;
   logic                    write_reg_enable;
   logic                    flags_reg_enable;
   logic                    ram_write_enable;
   logic                    halt;

   modport master (
      input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
      output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
             write_reg_enable, flags_reg_enable, ram_write_enable, halt
   );

   modport slave (
      output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
      input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
             write_reg_enable, flags_reg_enable, ram_write_enable, halt
   );

endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer for the K&S processor.
// Steps each instruction through FETCH / LOAD_IR / DECODE / execute and
// stretches RAM reads by RAM_LATENCY cycles (legal range 1..7).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; all outputs forced to 0 while low
//   cu    : control_unit_if.master (decode/flags in, control strobes out)
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   control_unit_if.master cu
);

   localparam int unsigned    CW   = $clog2(RAM_LATENCY + 1);
   localparam logic [CW-1:0] LAST = CW'(RAM_LATENCY - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   ctrl_state_type state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   ctrl_out_t      out_q, out_d, out_v;

   // Outputs are registered: they are computed for the state being entered,
   // so decode-dependent fields (operation, branch) are captured in DECODE,
   // when IR and the flags are already stable.
   function automatic ctrl_out_t state_outputs(ctrl_state_type s,
                                               decoded_instruction_type di,
                                               logic zero, logic neg);
      ctrl_out_t o;
      o = '0;
      case (s)
         LOAD_IR: begin
            o.ir_enable = 1'b1;
            o.pc_enable = 1'b1;
         end
         EXEC_ALU: begin
            o.write_reg_enable = 1'b1;
            o.operation        = alu_op(di);
            o.flags_reg_enable = (di != I_MOVE);
         end
         LOAD_WAIT: o.addr_sel = 1'b1;
         LOAD_WB: begin
            o.addr_sel         = 1'b1;
            o.c_sel            = 1'b1;
            o.write_reg_enable = 1'b1;
         end
         STORE: begin
            o.addr_sel         = 1'b1;
            o.ram_write_enable = 1'b1;
         end
         EXEC_BRANCH: begin
            o.pc_enable = 1'b1;
            o.branch    = branch_taken(di, zero, neg);
         end
         HALT:    o.halt = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         FETCH: begin
            if (cnt_q == LAST) state_d = LOAD_IR;
            else               cnt_d   = cnt_q + ONE;
         end
         LOAD_IR: state_d = DECODE;
         DECODE:  state_d = dispatch(cu.decoded_instruction);
         LOAD_WAIT: begin
            if (cnt_q == LAST) state_d = LOAD_WB;
            else               cnt_d   = cnt_q + ONE;
         end
         EXEC_ALU, LOAD_WB, STORE, EXEC_BRANCH: state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
      out_d = state_outputs(state_d, cu.decoded_instruction, cu.zero_op, cu.neg_op);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   // Combinational gate so no strobe can coincide with a reset edge.
   assign out_v = rst_n ? out_q : '0;

   assign cu.branch           = out_v.branch;
   assign cu.pc_enable        = out_v.pc_enable;
   assign cu.ir_enable        = out_v.ir_enable;
   assign cu.addr_sel         = out_v.addr_sel;
   assign cu.c_sel            = out_v.c_sel;
   assign cu.operation        = out_v.operation;
   assign cu.write_reg_enable = out_v.write_reg_enable;
   assign cu.flags_reg_enable = out_v.flags_reg_enable;
   assign cu.ram_write_enable = out_v.ram_write_enable;
   assign cu.halt             = out_v.halt;

   // Overflow flags are observed only; they have no control effect.
   logic unused_overflow;
   assign unused_overflow = cu.unsigned_overflow ^ cu.signed_overflow;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit.
// Two instances (RAM_LATENCY 1 and 3) share clock and reset; expected
// per-cycle output vectors are queued when an instruction is driven and
// compared cycle by cycle as the selected instance produces them.
module tb_control_unit;
   import k_and_s_pkg::*;

   localparam int unsigned LA = 1;
   localparam int unsigned LB = 3;

   // Vector layout: {halt, ram_we, flags_en, wr_en, op[1:0], c_sel, addr_sel, ir_en, pc_en, branch}
   localparam logic [10:0] M_BR = 11'h001;
   localparam logic [10:0] M_PC = 11'h002;
   localparam logic [10:0] M_IR = 11'h004;
   localparam logic [10:0] M_AS = 11'h008;
   localparam logic [10:0] M_CS = 11'h010;
   localparam logic [10:0] M_WR = 11'h080;
   localparam logic [10:0] M_FL = 11'h100;
   localparam logic [10:0] M_RW = 11'h200;
   localparam logic [10:0] M_HL = 11'h400;
   localparam logic [10:0] OP_ADD = 11'h000;
   localparam logic [10:0] OP_SUB = 11'h020;
   localparam logic [10:0] OP_AND = 11'h040;
   localparam logic [10:0] OP_OR  = 11'h060;

   logic                    clk;
   logic                    rst_n;
   decoded_instruction_type di;
   logic                    z, n, uo, so;

   control_unit_if if_a ();
   control_unit_if if_b ();

   assign if_a.decoded_instruction = di;
   assign if_a.zero_op             = z;
   assign if_a.neg_op              = n;
   assign if_a.unsigned_overflow   = uo;
   assign if_a.signed_overflow     = so;
   assign if_b.decoded_instruction = di;
   assign if_b.zero_op             = z;
   assign if_b.neg_op              = n;
   assign if_b.unsigned_overflow   = uo;
   assign if_b.signed_overflow     = so;

   control_unit #(.RAM_LATENCY(LA)) dut_a (.clk(clk), .rst_n(rst_n), .cu(if_a));
   control_unit #(.RAM_LATENCY(LB)) dut_b (.clk(clk), .rst_n(rst_n), .cu(if_b));

   logic [10:0] obs_a, obs_b;
   assign obs_a = {if_a.halt, if_a.ram_write_enable, if_a.flags_reg_enable, if_a.write_reg_enable,
                   if_a.operation, if_a.c_sel, if_a.addr_sel, if_a.ir_enable, if_a.pc_enable, if_a.branch};
   assign obs_b = {if_b.halt, if_b.ram_write_enable, if_b.flags_reg_enable, if_b.write_reg_enable,
                   if_b.operation, if_b.c_sel, if_b.addr_sel, if_b.ir_enable, if_b.pc_enable, if_b.branch};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] v;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks;
   int unsigned passed;

   task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic push(input logic [10:0] v, input string tag);
      exp_t e;
      e.v   = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Expected per-cycle outputs for one instruction, starting in FETCH.
   task automatic push_instr(input int unsigned lat, input decoded_instruction_type d,
                             input logic zz, input logic nn, input string name);
      for (int unsigned k = 0; k < lat; k++) push('0, {name, "_fetch"});
      push(M_IR | M_PC, {name, "_load_ir"});
      push('0, {name, "_decode"});
      case (d)
         I_ADD:    push(M_WR | M_FL | OP_ADD, {name, "_exec"});
         I_SUB:    push(M_WR | M_FL | OP_SUB, {name, "_exec"});
         I_AND:    push(M_WR | M_FL | OP_AND, {name, "_exec"});
         I_OR:     push(M_WR | M_FL | OP_OR,  {name, "_exec"});
         I_MOVE:   push(M_WR | OP_OR,         {name, "_exec"});
         I_LOAD: begin
            for (int unsigned k = 0; k < lat; k++) push(M_AS, {name, "_wait"});
            push(M_AS | M_CS | M_WR, {name, "_wb"});
         end
         I_STORE:  push(M_AS | M_RW, {name, "_store"});
         I_BRANCH: push(M_PC | M_BR, {name, "_br"});
         I_BZERO:  push(M_PC | (zz ? M_BR : 11'h000), {name, "_br"});
         I_BNZERO: push(M_PC | (zz ? 11'h000 : M_BR), {name, "_br"});
         I_BNEG:   push(M_PC | (nn ? M_BR : 11'h000), {name, "_br"});
         I_BNNEG:  push(M_PC | (nn ? 11'h000 : M_BR), {name, "_br"});
         I_HALT:   for (int unsigned k = 0; k < 20; k++) push(M_HL, {name, "_halt"});
         default:  ;
      endcase
   endtask

   task automatic run(input bit sel);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, sel ? obs_b : obs_a, e.v);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exec(input bit sel, input int unsigned lat, input decoded_instruction_type d,
                       input logic zz, input logic nn, input string name);
      di = d;
      z  = zz;
      n  = nn;
      uo = $urandom_range(0, 1);
      so = $urandom_range(0, 1);
      push_instr(lat, d, zz, nn, name);
      run(sel);
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_a"}, obs_a, '0);
      chk({name, "_b"}, obs_b, '0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      di     = I_NOP;
      z      = 1'b0;
      n      = 1'b0;
      uo     = 1'b0;
      so     = 1'b0;

      do_reset("reset1");
      exec(1'b0, LA, I_NOP,    1'b0, 1'b0, "a_nop");
      exec(1'b0, LA, I_ADD,    1'b0, 1'b0, "a_add");
      exec(1'b0, LA, I_MOVE,   1'b0, 1'b0, "a_move");
      exec(1'b0, LA, I_SUB,    1'b0, 1'b0, "a_sub");
      exec(1'b0, LA, I_AND,    1'b0, 1'b0, "a_and");
      exec(1'b0, LA, I_OR,     1'b0, 1'b0, "a_or");
      exec(1'b0, LA, I_LOAD,   1'b0, 1'b0, "a_load");
      exec(1'b0, LA, I_STORE,  1'b0, 1'b0, "a_store");
      exec(1'b0, LA, I_BZERO,  1'b0, 1'b0, "a_bzero_z0");
      exec(1'b0, LA, I_BZERO,  1'b1, 1'b0, "a_bzero_z1");
      exec(1'b0, LA, I_BNZERO, 1'b0, 1'b1, "a_bnzero_z0");
      exec(1'b0, LA, I_BNZERO, 1'b1, 1'b1, "a_bnzero_z1");
      exec(1'b0, LA, I_BNEG,   1'b1, 1'b1, "a_bneg_n1");
      exec(1'b0, LA, I_BNEG,   1'b1, 1'b0, "a_bneg_n0");
      exec(1'b0, LA, I_BNNEG,  1'b0, 1'b0, "a_bnneg_n0");
      exec(1'b0, LA, I_BNNEG,  1'b0, 1'b1, "a_bnneg_n1");
      exec(1'b0, LA, I_BRANCH, 1'b0, 1'b0, "a_branch");
      exec(1'b0, LA, decoded_instruction_type'(4'hD), 1'b0, 1'b0, "a_unknown");
      exec(1'b0, LA, I_HALT,   1'b0, 1'b0, "a_halt");

      do_reset("reset2");
      exec(1'b1, LB, I_NOP,    1'b0, 1'b0, "b_nop");
      exec(1'b1, LB, I_LOAD,   1'b0, 1'b0, "b_load");
      exec(1'b1, LB, I_STORE,  1'b0, 1'b0, "b_store");
      exec(1'b1, LB, I_ADD,    1'b0, 1'b0, "b_add");
      exec(1'b1, LB, I_BNEG,   1'b0, 1'b1, "b_bneg");

      // Abort a LOAD during its second LOAD_WAIT cycle.
      di = I_LOAD;
      for (int unsigned k = 0; k < LB; k++) push('0, "abort_fetch");
      push(M_IR | M_PC, "abort_load_ir");
      push('0, "abort_decode");
      push(M_AS, "abort_wait1");
      run(1'b1);
      chk("abort_wait2", obs_b, M_AS);
      rst_n = 1'b0;
      #1;
      chk("abort_forced_zero", obs_b, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exec(1'b1, LB, I_ADD,    1'b0, 1'b0, "b_after_abort");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
